seq_scan_ctrl: RTL and testbench

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

---
 rtl/seq_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_seq_scan_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
// Serial pattern scanner: feeds frame bytes MSB-first through a history
// register and counts (overlapping or non-overlapping) pattern matches.
// Ports: clk, rst (sync, active-high); start/frame_len/pattern/overlap
// request a frame; data_in/data_valid/data_ready byte handshake;
// busy, match (pulse), match_count, done (pulse) status.
module seq_scan_ctrl #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       frame_len,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             done
);

  localparam int VW = $clog2(PAT_W + 1);
  localparam logic [VW-1:0] VMAX = VW'(PAT_W);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [PAT_W-1:0] pat;
  logic             ovl;
  logic [PAT_W-1:0] hist;
  logic [VW-1:0]    vcnt;
  logic [7:0]       sreg;
  logic [2:0]       bitcnt;
  logic [7:0]       rem;
  logic             match_q;
  logic [CNT_W-1:0] mcnt;

  logic [PAT_W-1:0] hist_nx;
  logic [VW-1:0]    vcnt_nx;
  logic             hit;

  always_comb begin
    hist_nx = {hist[PAT_W-2:0], sreg[7]};
    vcnt_nx = (vcnt == VMAX) ? VMAX : vcnt + 1'b1;
    hit     = (hist_nx == pat) && (vcnt_nx == VMAX);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (frame_len == 8'd0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (data_valid) begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (bitcnt == 3'd7) begin
          state_nx = (rem == 8'd1) ? DONE : LOAD;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pat     <= '0;
      ovl     <= 1'b0;
      hist    <= '0;
      vcnt    <= '0;
      sreg    <= '0;
      bitcnt  <= '0;
      rem     <= '0;
      match_q <= 1'b0;
      mcnt    <= '0;
    end else begin
      state   <= state_nx;
      match_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pat    <= pattern;
            ovl    <= overlap;
            rem    <= frame_len;
            hist   <= '0;
            vcnt   <= '0;
            mcnt   <= '0;
            bitcnt <= '0;
          end
        end
        LOAD: begin
          if (data_valid) begin
            sreg   <= data_in;
            bitcnt <= '0;
          end
        end
        SHIFT: begin
          sreg   <= {sreg[6:0], 1'b0};
          bitcnt <= bitcnt + 1'b1;
          hist   <= hist_nx;
          // non-overlap mode demands PAT_W fresh bits after a hit
          vcnt   <= (hit && !ovl) ? '0 : vcnt_nx;
          if (hit) begin
            match_q <= 1'b1;
            if (!(&mcnt)) begin
              mcnt <= mcnt + 1'b1;
            end
          end
          if (bitcnt == 3'd7) begin
            rem <= rem - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs forced low while reset is held, even before the edge
  assign data_ready  = (state == LOAD) && !rst;
  assign busy        = ((state == LOAD) || (state == SHIFT)) && !rst;
  assign done        = (state == DONE) && !rst;
  assign match       = match_q && !rst;
  assign match_count = rst ? '0 : mcnt;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: overlap, non-overlap, cross-byte,
// empty frame, stall with ignored start, and mid-scan reset.
module tb_seq_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] frame_len;
  logic [4:0] pattern;
  logic       overlap;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       match;
  logic [7:0] match_count;
  logic       done;

  int errs;
  int checks;

  logic [7:0] mv;
  logic       dn;

  seq_scan_ctrl #(.PAT_W(5), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .frame_len   (frame_len),
    .pattern     (pattern),
    .overlap     (overlap),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .match       (match),
    .match_count (match_count),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] len,
                             input logic [4:0] pat,
                             input logic ov);
    start     = 1'b1;
    frame_len = len;
    pattern   = pat;
    overlap   = ov;
    tick();
    start = 1'b0;
  endtask

  // assumes LOAD; returns per-bit match vector and done after bit 0
  task automatic run_byte(input logic [7:0] b,
                          output logic [7:0] m,
                          output logic d);
    data_in    = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      m[k] = match;
    end
    d = done;
  endtask

  initial begin
    errs       = 0;
    checks     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    frame_len  = 8'd0;
    pattern    = 5'b0;
    overlap    = 1'b0;
    data_in    = 8'd0;
    data_valid = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", data_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", match_count, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // overlapping: 0xDB -> hits after bits 4 and 7
    start_frame(8'd1, 5'b11011, 1'b1);
    chk("ov_busy", busy, 1);
    chk("ov_ready", data_ready, 1);
    run_byte(8'hDB, mv, dn);
    chk("ov_mvec", mv, 8'b1001_0000);
    chk("ov_done", dn, 1);
    chk("ov_dbusy", busy, 0);
    chk("ov_cnt", match_count, 2);
    tick();
    chk("ov_done_clr", done, 0);
    chk("ov_cnt_hold", match_count, 2);

    // non-overlapping
    start_frame(8'd1, 5'b11011, 1'b0);
    chk("no_cnt_clr", match_count, 0);
    run_byte(8'hDB, mv, dn);
    chk("no_mvec", mv, 8'b0001_0000);
    chk("no_done", dn, 1);
    chk("no_cnt", match_count, 1);
    tick();

    // cross-byte: 0x03,0x60 -> hit on 3rd bit of byte 2
    start_frame(8'd2, 5'b11011, 1'b1);
    run_byte(8'h03, mv, dn);
    chk("xb_mvec1", mv, 8'h00);
    chk("xb_done1", dn, 0);
    chk("xb_ready", data_ready, 1);
    run_byte(8'h60, mv, dn);
    chk("xb_mvec2", mv, 8'b0000_0100);
    chk("xb_done2", dn, 1);
    chk("xb_cnt", match_count, 1);
    tick();

    // empty frame
    start_frame(8'd0, 5'b11011, 1'b1);
    chk("em_done", done, 1);
    chk("em_busy", busy, 0);
    chk("em_cnt", match_count, 0);
    tick();
    chk("em_done_clr", done, 0);
    chk("em_busy2", busy, 0);

    // stall in LOAD with start and config churn ignored
    start_frame(8'd1, 5'b11011, 1'b1);
    start     = 1'b1;
    frame_len = 8'd0;
    pattern   = 5'b00000;
    overlap   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_busy", busy, 1);
      chk("st_ready", data_ready, 1);
      chk("st_match", match, 0);
      chk("st_done", done, 0);
    end
    run_byte(8'hDB, mv, dn);
    start = 1'b0;
    chk("st_mvec", mv, 8'b1001_0000);
    chk("st_done2", dn, 1);
    chk("st_cnt", match_count, 2);
    tick();
    chk("st_idle", busy, 0);

    // mid-scan reset, byte 1 of 2
    start_frame(8'd2, 5'b11011, 1'b1);
    data_in    = 8'hDB;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    tick();
    tick();
    rst        = 1'b1;
    start      = 1'b1;
    data_valid = 1'b1;
    tick();
    chk("mr_busy", busy, 0);
    chk("mr_ready", data_ready, 0);
    chk("mr_match", match, 0);
    chk("mr_done", done, 0);
    chk("mr_cnt", match_count, 0);
    rst        = 1'b0;
    start      = 1'b0;
    data_valid = 1'b0;
    tick();
    chk("mr_idle", busy, 0);
    chk("mr_idle_cnt", match_count, 0);
    start_frame(8'd1, 5'b11011, 1'b0);
    run_byte(8'hDB, mv, dn);
    chk("mr_mvec", mv, 8'b0001_0000);
    chk("mr_done2", dn, 1);
    chk("mr_cnt2", match_count, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
